// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory port sequencer.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W    = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    FIN  = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_byte_assembler.sv
// Big-endian byte assembler: each capture shifts the word left one byte and
// appends the incoming byte, so the first byte read ends up most significant.
module imem_byte_assembler
  import imem_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cap_en,
  input  logic [7:0]                    byte_in,
  output logic [8*BYTES_PER_WORD-1:0]   word
);

  logic [8*BYTES_PER_WORD-1:0] word_q;
  logic [8*BYTES_PER_WORD-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (cap_en) begin
      word_d = {word_q[8*BYTES_PER_WORD-9:0], byte_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/imem_port_sequencer.sv
// Single byte-wide instruction-memory port shared by the program loader
// (byte writes) and the fetch path (4-byte big-endian instruction reads).
module imem_port_sequencer
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W         = IMEM_ADDR_W,
  parameter int unsigned LOAD_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic              addr_err,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned BURST_W = $clog2(LOAD_BURST_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(LOAD_BURST_MAX);
  // Highest base address whose four bytes fit without wrapping.
  localparam logic [32:0] ERR_LIMIT = (33'd1 << ADDR_W) - 33'd4;

  imem_state_e         state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                err_q, err_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [31:0]         instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                asm_en;
  logic [31:0]         asm_word;
  logic                burst_open;

  imem_byte_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .cap_en  (asm_en),
    .byte_in (mem_rdata),
    .word    (asm_word)
  );

  assign burst_open = (burst_q < BURST_LIMIT);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    base_d        = base_q;
    err_d         = err_q;
    burst_d       = burst_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    addr_err_d    = 1'b0;
    fetch_ready   = 1'b0;
    load_ready    = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    asm_en        = 1'b0;

    if (!fetch_req) begin
      burst_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (load_valid && (burst_open || !fetch_req)) begin
          load_ready = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = load_addr;
          mem_wdata  = load_data;
          if (fetch_req && burst_open) begin
            burst_d = burst_q + 1'b1;
          end
        end else if (fetch_req) begin
          fetch_ready = 1'b1;
          base_d      = fetch_addr[ADDR_W-1:0];
          err_d       = ({1'b0, fetch_addr} > ERR_LIMIT);
          idx_d       = 2'd0;
          burst_d     = '0;
          state_d     = RD;
        end
      end
      RD: begin
        mem_addr = base_q + ADDR_W'(idx_q);
        // Read data lags the address by one cycle, so byte idx-1 arrives now.
        asm_en   = (idx_q != 2'd0);
        idx_d    = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = FIN;
        end
      end
      FIN: begin
        asm_en        = 1'b1;
        instr_d       = {asm_word[23:0], mem_rdata};
        instr_valid_d = 1'b1;
        addr_err_d    = err_q;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      fetch_ready = 1'b0;
      load_ready  = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      base_q        <= '0;
      err_q         <= 1'b0;
      burst_q       <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
      err_q         <= err_d;
      burst_q       <= burst_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_imem_port_sequencer.sv
// Directed bench for imem_port_sequencer with a behavioural byte memory.
module tb_imem_port_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        addr_err;
  logic        load_valid;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic        load_ready;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  imem_port_sequencer #(.ADDR_W(8), .LOAD_BURST_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .addr_err    (addr_err),
    .load_valid  (load_valid),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // One loader write cycle; reports whether the DUT accepted and forwarded it.
  task automatic load_byte(input logic [7:0] a, input logic [7:0] d, output logic ok);
    @(negedge clk);
    load_valid = 1'b1; load_addr = a; load_data = d;
    #1;
    ok = load_ready && mem_we && (mem_addr == a) && (mem_wdata == d);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Issue a fetch and wait (bounded) for completion; lat=-1 if it never completes.
  task automatic fetch_collect(input logic [31:0] a, output logic [31:0] got,
                               output logic err, output int lat);
    int w;
    lat = -1; got = '0; err = 1'b0; w = 0;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = a;
    #1;
    while (!fetch_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (fetch_ready) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk); fetch_req = 1'b0; #1;
        if (instr_valid) begin
          got = instr; err = addr_err; lat = k;
          break;
        end
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = 32'd20;
    load_valid = 1'b1; load_addr = 8'h33; load_data = 8'h44;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({load_ready, fetch_ready, mem_we} !== 3'b000 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
        failures++;
        $display("FAIL reset_gating: lr=%b fr=%b we=%b addr=%h wdata=%h required all zero",
                 load_ready, fetch_ready, mem_we, mem_addr, mem_wdata);
      end
    end
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: valid=%b instr=%h err=%b required 0/00000000/0", instr_valid, instr, addr_err);
    end
    @(negedge clk);
    rst = 1'b0; fetch_req = 1'b0; load_valid = 1'b0;
  endtask

  task automatic test_preload_fetch();
    logic [7:0] bytes [4];
    logic ok;
    bytes[0] = 8'h20; bytes[1] = 8'h08; bytes[2] = 8'h00; bytes[3] = 8'h05;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b1; load_addr = 8'(20 + i); load_data = bytes[i];
      #1;
      ok = load_ready && mem_we && (mem_addr == 8'(20 + i)) && (mem_wdata == bytes[i]);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL preload_write%0d: lr=%b we=%b addr=%h wdata=%h required 1/1/%h/%h",
                 i, load_ready, mem_we, mem_addr, mem_wdata, 8'(20 + i), bytes[i]);
      end
    end
    @(negedge clk);
    load_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 32'd20;
    #1;
    checks++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL preload_accept: fetch_ready=%b required 1", fetch_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); fetch_req = 1'b0; #1;
      checks++;
      if (mem_addr !== 8'(19 + k) || mem_we !== 1'b0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL preload_rd_T%0d: addr=%h we=%b valid=%b required %h/0/0",
                 k, mem_addr, mem_we, instr_valid, 8'(19 + k));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL preload_T5: valid=%b required 0", instr_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h20080005 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL preload_T6: valid=%b instr=%h err=%b required 1/20080005/0", instr_valid, instr, addr_err);
    end
    @(negedge clk); #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h20080005) begin
      failures++;
      $display("FAIL preload_hold: valid=%b instr=%h required 0/20080005", instr_valid, instr);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    load_valid = 1'b1; load_addr = 8'd100; load_data = 8'h5A;
    fetch_req = 1'b1; fetch_addr = 32'd20;
    #1;
    checks++;
    if (load_ready !== 1'b1 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL collision_same: lr=%b fr=%b required 1/0", load_ready, fetch_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    checks++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL collision_next: fetch_ready=%b required 1", fetch_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); fetch_req = 1'b0; #1;
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h20080005) begin
      failures++;
      $display("FAIL collision_instr: valid=%b instr=%h required 1/20080005", instr_valid, instr);
    end
  endtask

  task automatic test_fairness();
    int grants = 0;
    int blocked = 0;
    logic seen = 1'b0;
    logic lr_at_grant = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      load_valid = 1'b1; load_addr = 8'(100 + i); load_data = 8'(i);
      fetch_req = 1'b1; fetch_addr = 32'd20;
      #1;
      if (fetch_ready) begin
        seen = 1'b1; lr_at_grant = load_ready;
      end else if (load_ready) begin
        grants++;
      end
    end
    checks++;
    if (!seen || grants != 4 || lr_at_grant !== 1'b0) begin
      failures++;
      $display("FAIL fairness_grants: loader grants=%0d fetch granted=%b lr_at_grant=%b required 4/1/0",
               grants, seen, lr_at_grant);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); fetch_req = 1'b0; #1;
      if (load_ready || fetch_ready) blocked++;
    end
    checks++;
    if (blocked != 0) begin
      failures++;
      $display("FAIL fairness_no_preempt: grants during fetch=%0d required 0", blocked);
    end
    @(negedge clk); #1;
    checks++;
    if (instr_valid !== 1'b1 || load_ready !== 1'b1 || instr !== 32'h20080005) begin
      failures++;
      $display("FAIL fairness_resume: valid=%b lr=%b instr=%h required 1/1/20080005",
               instr_valid, load_ready, instr);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic ok;
    logic all_ok = 1'b1;
    logic [31:0] got;
    logic err;
    int lat;
    load_byte(8'd254, 8'hAA, ok); all_ok &= ok;
    load_byte(8'd255, 8'hBB, ok); all_ok &= ok;
    load_byte(8'd0,   8'hCC, ok); all_ok &= ok;
    load_byte(8'd1,   8'hDD, ok); all_ok &= ok;
    load_byte(8'd252, 8'h11, ok); all_ok &= ok;
    load_byte(8'd253, 8'h22, ok); all_ok &= ok;
    checks++;
    if (!all_ok) begin
      failures++;
      $display("FAIL wrap_loads: accepted=%b required 1", all_ok);
    end
    fetch_collect(32'd254, got, err, lat);
    checks++;
    if (got !== 32'hAABBCCDD || err !== 1'b1 || lat != 6) begin
      failures++;
      $display("FAIL wrap_254: instr=%h err=%b lat=%0d required aabbccdd/1/6", got, err, lat);
    end
    fetch_collect(32'd252, got, err, lat);
    checks++;
    if (got !== 32'h1122AABB || err !== 1'b0 || lat != 6) begin
      failures++;
      $display("FAIL edge_252: instr=%h err=%b lat=%0d required 1122aabb/0/6", got, err, lat);
    end
    fetch_collect(32'h0000_0114, got, err, lat);
    checks++;
    if (got !== 32'h20080005 || err !== 1'b1 || lat != 6) begin
      failures++;
      $display("FAIL high_bits: instr=%h err=%b lat=%0d required 20080005/1/6", got, err, lat);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'd20;
    #1;
    checks++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_accept: fetch_ready=%b required 1", fetch_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) fetch_addr = 32'd254;
      #1;
    end
    checks++;
    if (instr_valid !== 1'b1 || fetch_ready !== 1'b1 || instr !== 32'h20080005) begin
      failures++;
      $display("FAIL b2b_overlap: valid=%b fr=%b instr=%h required 1/1/20080005", instr_valid, fetch_ready, instr);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); fetch_req = 1'b0; #1;
    end
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hAABBCCDD || addr_err !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: valid=%b instr=%h err=%b required 1/aabbccdd/1", instr_valid, instr, addr_err);
    end
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    logic [31:0] got;
    logic err;
    int lat;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'd20;
    #1;
    checks++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_accept: fetch_ready=%b required 1", fetch_ready);
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); fetch_req = 1'b0; #1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_addr !== 8'h00 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_port: addr=%h we=%b required 00/0", mem_addr, mem_we);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (instr_valid) spurious++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (instr_valid) spurious++;
    end
    checks++;
    if (spurious != 0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_abort: valid pulses=%0d instr=%h required 0/00000000", spurious, instr);
    end
    fetch_collect(32'd20, got, err, lat);
    checks++;
    if (got !== 32'h20080005 || err !== 1'b0 || lat != 6) begin
      failures++;
      $display("FAIL rstmid_refetch: instr=%h err=%b lat=%0d required 20080005/0/6", got, err, lat);
    end
  endtask

  initial begin
    test_reset();
    test_preload_fetch();
    test_collision();
    test_fairness();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
